// File: rtl/reg_decode_operand_unit_pkg.sv
// rtl/reg_decode_operand_unit_pkg.sv - operand select encodings shared by decode and execute
package reg_decode_operand_unit_pkg;

    localparam int OP1_W = 2;
    localparam int OP2_W = 3;

    typedef enum logic [OP1_W-1:0] {
        OP1_X   = 2'd0,
        OP1_RS1 = 2'd1,
        OP1_PC  = 2'd2
    } op1_sel_e;

    typedef enum logic [OP2_W-1:0] {
        OP2_X   = 3'd0,
        OP2_RS2 = 3'd1,
        OP2_IMI = 3'd2,
        OP2_IMS = 3'd3,
        OP2_IMJ = 3'd4,
        OP2_IMU = 3'd5
    } op2_sel_e;

endpackage

// File: rtl/reg_decode_operand_unit_reg_file_mw.sv
// rtl/reg_decode_operand_unit_reg_file_mw.sv - multi-write-port register file with bypassed reads
module reg_file_mw #(
    parameter int  XLEN = 32,
    parameter int  NREG = 32,
    parameter int  NWB  = 2,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NWB-1:0]           wb_en,
    input  logic [NWB*AW-1:0]        wb_addr,
    input  logic [NWB*XLEN-1:0]      wb_data,
    input  logic [1:0][AW-1:0]       raddr,
    output logic [1:0][XLEN-1:0]     rdata
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];

    // Ports are applied in ascending order so the younger (higher) port wins.
    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NWB; i++) begin
            if (wb_en[i]) begin
                regs_d[wb_addr[i*AW +: AW]] = wb_data[i*XLEN +: XLEN];
            end
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdata[p] = regs_q[raddr[p]];
            for (int i = 0; i < NWB; i++) begin
                if (wb_en[i] && (wb_addr[i*AW +: AW] == raddr[p])) begin
                    rdata[p] = wb_data[i*XLEN +: XLEN];
                end
            end
            if (raddr[p] == '0) begin
                rdata[p] = '0;
            end
        end
    end

endmodule

// File: rtl/reg_decode_operand_unit.sv
// rtl/reg_decode_operand_unit.sv - decode-stage regfile, operand select, scoreboard and output stage
module reg_decode_operand_unit
    import reg_decode_operand_unit_pkg::*;
#(
    parameter int  XLEN = 32,
    parameter int  NREG = 32,
    parameter int  NWB  = 2,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [AW-1:0]         op1_addr,
    input  logic [AW-1:0]         op2_addr,
    input  logic [AW-1:0]         rd_addr,
    input  logic                  rd_en,
    input  logic [XLEN-1:0]       pc,
    input  logic [XLEN-1:0]       imm,
    input  logic [OP1_W-1:0]      op1,
    input  logic [OP2_W-1:0]      op2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       rs1_data,
    output logic [XLEN-1:0]       rs2_data,
    output logic [AW-1:0]         out_rd_addr,
    output logic                  out_rd_en,
    input  logic                  flush,
    input  logic [NWB-1:0]        wb_en,
    input  logic [NWB*AW-1:0]     wb_addr,
    input  logic [NWB*XLEN-1:0]   wb_data,
    output logic [NREG-1:0]       busy
);

    logic [1:0][XLEN-1:0] rf_rdata;
    logic [XLEN-1:0]      op1_val;
    logic [XLEN-1:0]      op2_val;
    logic [NREG-1:0]      wb_hit;
    logic [NREG-1:0]      busy_eff;
    logic                 stall;
    logic                 accept;

    logic                 out_valid_q,   out_valid_d;
    logic [XLEN-1:0]      rs1_q,         rs1_d;
    logic [XLEN-1:0]      rs2_q,         rs2_d;
    logic [AW-1:0]        out_rd_addr_q, out_rd_addr_d;
    logic                 out_rd_en_q,   out_rd_en_d;
    logic [NREG-1:0]      busy_q,        busy_d;

    reg_file_mw #(
        .XLEN (XLEN),
        .NREG (NREG),
        .NWB  (NWB)
    ) u_rf (
        .clk     (clk),
        .reset   (reset),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .raddr   ({op2_addr, op1_addr}),
        .rdata   (rf_rdata)
    );

    always_comb begin
        case (op1)
            OP1_RS1: op1_val = rf_rdata[0];
            OP1_PC:  op1_val = pc;
            default: op1_val = '0;
        endcase
    end

    always_comb begin
        case (op2)
            OP2_RS2:                         op2_val = rf_rdata[1];
            OP2_IMI, OP2_IMS, OP2_IMJ, OP2_IMU: op2_val = imm;
            default:                         op2_val = '0;
        endcase
    end

    // A write-back landing this cycle is bypassed, so it also resolves the hazard.
    always_comb begin
        wb_hit = '0;
        for (int i = 0; i < NWB; i++) begin
            if (wb_en[i]) begin
                wb_hit[wb_addr[i*AW +: AW]] = 1'b1;
            end
        end
    end

    assign busy_eff = busy_q & ~wb_hit;
    assign stall    = ((op1 == OP1_RS1) && busy_eff[op1_addr])
                   || ((op2 == OP2_RS2) && busy_eff[op2_addr])
                   || (rd_en && busy_eff[rd_addr]);
    assign in_ready = !stall && !flush && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid_d   = out_valid_q;
        rs1_d         = rs1_q;
        rs2_d         = rs2_q;
        out_rd_addr_d = out_rd_addr_q;
        out_rd_en_d   = out_rd_en_q;
        busy_d        = busy_q & ~wb_hit;
        if (flush) begin
            out_valid_d = 1'b0;
            if (out_valid_q && out_rd_en_q) begin
                busy_d[out_rd_addr_q] = 1'b0;
            end
        end else if (accept) begin
            out_valid_d   = 1'b1;
            rs1_d         = op1_val;
            rs2_d         = op2_val;
            out_rd_addr_d = rd_addr;
            out_rd_en_d   = rd_en && (rd_addr != '0);
            if (rd_en && (rd_addr != '0)) begin
                busy_d[rd_addr] = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q   <= 1'b0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            out_rd_addr_q <= '0;
            out_rd_en_q   <= 1'b0;
            busy_q        <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            rs1_q         <= rs1_d;
            rs2_q         <= rs2_d;
            out_rd_addr_q <= out_rd_addr_d;
            out_rd_en_q   <= out_rd_en_d;
            busy_q        <= busy_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign rs1_data    = rs1_q;
    assign rs2_data    = rs2_q;
    assign out_rd_addr = out_rd_addr_q;
    assign out_rd_en   = out_rd_en_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_reg_decode_operand_unit.sv
// tb/tb_reg_decode_operand_unit.sv - directed self-checking bench for reg_decode_operand_unit
module tb_reg_decode_operand_unit;
    import reg_decode_operand_unit_pkg::*;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NWB  = 2;
    localparam int AW   = 5;

    logic                 clk;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic [AW-1:0]        op1_addr;
    logic [AW-1:0]        op2_addr;
    logic [AW-1:0]        rd_addr;
    logic                 rd_en;
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      imm;
    logic [OP1_W-1:0]     op1;
    logic [OP2_W-1:0]     op2;
    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      rs1_data;
    logic [XLEN-1:0]      rs2_data;
    logic [AW-1:0]        out_rd_addr;
    logic                 out_rd_en;
    logic                 flush;
    logic [NWB-1:0]       wb_en;
    logic [NWB*AW-1:0]    wb_addr;
    logic [NWB*XLEN-1:0]  wb_data;
    logic [NREG-1:0]      busy;

    int checks = 0;
    int errors = 0;

    reg_decode_operand_unit #(.XLEN(XLEN), .NREG(NREG), .NWB(NWB)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op1_addr(op1_addr), .op2_addr(op2_addr), .rd_addr(rd_addr), .rd_en(rd_en),
        .pc(pc), .imm(imm), .op1(op1), .op2(op2), .out_valid(out_valid), .out_ready(out_ready),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .out_rd_addr(out_rd_addr), .out_rd_en(out_rd_en),
        .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; op1 = OP1_X; op2 = OP2_X;
        op1_addr = '0; op2_addr = '0; rd_addr = '0; rd_en = 1'b0;
        pc = '0; imm = '0; flush = 1'b0; out_ready = 1'b1;
        wb_en = '0; wb_addr = '0; wb_data = '0;
    endtask

    task automatic set_wb(input int port, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        wb_en[port] = 1'b1;
        wb_addr[port*AW +: AW] = a;
        wb_data[port*XLEN +: XLEN] = d;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        set_wb(0, 5'd5, 32'h77);
        in_valid = 1'b1; op1 = OP1_RS1; op1_addr = 5'd5; rd_en = 1'b1; rd_addr = 5'd6;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_pre_ready got %b want 1", in_ready); end
        tick();
        checks++;
        if (rs1_data !== 32'h77) begin errors++; $display("FAIL reset_pre_rs1 got %h want 00000077", rs1_data); end
        checks++;
        if (busy !== 32'h0000_0040) begin errors++; $display("FAIL reset_pre_busy got %h want 00000040", busy); end
        idle_inputs();
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_rd_en, out_rd_addr} !== 7'd0) begin
            errors++; $display("FAIL reset_ctrl got v=%b en=%b rd=%0d want 0 0 0", out_valid, out_rd_en, out_rd_addr);
        end
        checks++;
        if ({rs1_data, rs2_data} !== 64'd0) begin
            errors++; $display("FAIL reset_data got %h %h want 0 0", rs1_data, rs2_data);
        end
        checks++;
        if (busy !== 32'd0) begin errors++; $display("FAIL reset_busy got %h want 0", busy); end
        tick();
        reset = 1'b1;
        in_valid = 1'b1; op1 = OP1_RS1; op1_addr = 5'd5;
        tick();
        checks++;
        if (out_valid !== 1'b1 || rs1_data !== 32'd0) begin
            errors++; $display("FAIL reset_read_x5 got v=%b rs1=%h want 1 00000000", out_valid, rs1_data);
        end
        idle_inputs();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_drain got %b want 0", out_valid); end
    endtask

    task automatic test_write_bypass();
        idle_inputs();
        set_wb(0, 5'd3, 32'h1234);
        in_valid = 1'b1; op1 = OP1_RS1; op1_addr = 5'd3;
        tick();
        checks++;
        if (rs1_data !== 32'h1234) begin errors++; $display("FAIL bypass_x3 got %h want 00001234", rs1_data); end
        idle_inputs();
        set_wb(0, 5'd7, 32'hA);
        set_wb(1, 5'd7, 32'hB);
        tick();
        idle_inputs();
        set_wb(0, 5'd0, 32'hDEAD);
        in_valid = 1'b1; op1 = OP1_RS1; op1_addr = 5'd7; op2 = OP2_RS2; op2_addr = 5'd0;
        tick();
        checks++;
        if (rs1_data !== 32'hB) begin errors++; $display("FAIL wb_conflict_x7 got %h want 0000000b", rs1_data); end
        checks++;
        if (rs2_data !== 32'd0) begin errors++; $display("FAIL x0_bypass got %h want 0", rs2_data); end
        idle_inputs();
        in_valid = 1'b1; op1 = OP1_RS1; op1_addr = 5'd0; op2 = OP2_RS2; op2_addr = 5'd3;
        tick();
        checks++;
        if (rs1_data !== 32'd0 || rs2_data !== 32'h1234) begin
            errors++; $display("FAIL x0_array got %h %h want 00000000 00001234", rs1_data, rs2_data);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_raw_stall();
        idle_inputs();
        in_valid = 1'b1; rd_en = 1'b1; rd_addr = 5'd4;
        tick();
        checks++;
        if (busy[4] !== 1'b1) begin errors++; $display("FAIL raw_busy_set got %b want 1", busy[4]); end
        rd_en = 1'b0; rd_addr = '0; op1 = OP1_RS1; op1_addr = 5'd4;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_stall0 got %b want 0", in_ready); end
        tick();
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL raw_stall1 got rdy=%b v=%b want 0 0", in_ready, out_valid);
        end
        set_wb(0, 5'd4, 32'h55);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_release got %b want 1", in_ready); end
        tick();
        checks++;
        if (rs1_data !== 32'h55 || out_valid !== 1'b1) begin
            errors++; $display("FAIL raw_data got v=%b rs1=%h want 1 00000055", out_valid, rs1_data);
        end
        checks++;
        if (busy[4] !== 1'b0) begin errors++; $display("FAIL raw_busy_clear got %b want 0", busy[4]); end
        idle_inputs();
        tick();
    endtask

    task automatic test_select();
        idle_inputs();
        in_valid = 1'b1; op1 = OP1_PC; pc = 32'h100; op2 = OP2_IMU; imm = 32'hABC0_0000;
        tick();
        checks++;
        if (rs1_data !== 32'h100 || rs2_data !== 32'hABC0_0000) begin
            errors++; $display("FAIL sel_pc_imu got %h %h want 00000100 abc00000", rs1_data, rs2_data);
        end
        op1 = 2'd3; op2 = 3'd7; pc = 32'h5; imm = 32'hFFFF;
        tick();
        checks++;
        if (rs1_data !== 32'd0 || rs2_data !== 32'd0) begin
            errors++; $display("FAIL sel_invalid got %h %h want 0 0", rs1_data, rs2_data);
        end
        op1 = OP1_X; op2 = OP2_IMI; imm = 32'h7;
        tick();
        checks++;
        if (rs1_data !== 32'd0 || rs2_data !== 32'h7) begin
            errors++; $display("FAIL sel_x_imi got %h %h want 00000000 00000007", rs1_data, rs2_data);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_backpressure();
        idle_inputs();
        out_ready = 1'b0;
        in_valid = 1'b1; op1 = OP1_PC; pc = 32'h200; rd_en = 1'b1; rd_addr = 5'd10;
        tick();
        checks++;
        if (out_valid !== 1'b1 || rs1_data !== 32'h200 || out_rd_addr !== 5'd10 || out_rd_en !== 1'b1) begin
            errors++; $display("FAIL bp_first got v=%b rs1=%h rd=%0d en=%b want 1 00000200 10 1",
                               out_valid, rs1_data, out_rd_addr, out_rd_en);
        end
        pc = 32'h300; rd_en = 1'b0; rd_addr = '0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_%0d got %b want 0", c, in_ready); end
            tick();
            checks++;
            if (out_valid !== 1'b1 || rs1_data !== 32'h200) begin
                errors++; $display("FAIL bp_hold_%0d got v=%b rs1=%h want 1 00000200", c, out_valid, rs1_data);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %b want 1", in_ready); end
        tick();
        checks++;
        if (out_valid !== 1'b1 || rs1_data !== 32'h300 || out_rd_en !== 1'b0) begin
            errors++; $display("FAIL bp_next got v=%b rs1=%h en=%b want 1 00000300 0", out_valid, rs1_data, out_rd_en);
        end
        idle_inputs();
        set_wb(0, 5'd10, 32'd0);
        tick();
        checks++;
        if (busy !== 32'd0) begin errors++; $display("FAIL bp_busy_clear got %h want 0", busy); end
    endtask

    task automatic test_flush();
        idle_inputs();
        out_ready = 1'b0;
        in_valid = 1'b1; rd_en = 1'b1; rd_addr = 5'd9;
        tick();
        checks++;
        if (out_valid !== 1'b1 || busy !== 32'h0000_0200) begin
            errors++; $display("FAIL flush_setup got v=%b busy=%h want 1 00000200", out_valid, busy);
        end
        rd_en = 1'b0; rd_addr = '0; op1 = OP1_PC; pc = 32'h400; flush = 1'b1;
        set_wb(0, 5'd2, 32'h22);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b want 0", in_ready); end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", out_valid); end
        checks++;
        if (busy !== 32'd0) begin errors++; $display("FAIL flush_busy got %h want 0", busy); end
        idle_inputs();
        in_valid = 1'b1; op1 = OP1_RS1; op1_addr = 5'd2;
        tick();
        checks++;
        if (out_valid !== 1'b1 || rs1_data !== 32'h22) begin
            errors++; $display("FAIL flush_wb_x2 got v=%b rs1=%h want 1 00000022", out_valid, rs1_data);
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        idle_inputs();
        test_reset();
        test_write_bypass();
        test_raw_stall();
        test_select();
        test_backpressure();
        test_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
